// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Write-back request, status and register-file write bus.
// Revision    : 1.0
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              AluValid;
    logic [ADDR_W-1:0] AluReg;
    logic [DATA_W-1:0] AluData;
    logic              AluReady;
    logic              MemValid;
    logic [ADDR_W-1:0] MemReg;
    logic [DATA_W-1:0] MemData;
    logic              MemReady;
    logic              ClearReq;
    logic              Busy;
    logic              ZeroDrop;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;

    modport master (
        output AluValid, AluReg, AluData, MemValid, MemReg, MemData, ClearReq,
        input  AluReady, MemReady, Busy, ZeroDrop, WriteRegister, WriteData, RegWrite
    );

    modport slave (
        input  AluValid, AluReg, AluData, MemValid, MemReg, MemData, ClearReq,
        output AluReady, MemReady, Busy, ZeroDrop, WriteRegister, WriteData, RegWrite
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Register-file write-port controller: clear sequence plus
//               round-robin ALU/load write-back arbitration.
// Revision    : 1.0
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  wire logic                 Clk,
    input  wire logic                 Rst_n,
    regfile_wb_arbiter_if.slave       bus
);
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clrIdx;
    logic              r_prio;      // 0: ALU wins next contest, 1: load wins
    logic              r_regWrite;
    logic              r_zeroDrop;
    logic [ADDR_W-1:0] r_writeReg;
    logic [DATA_W-1:0] r_writeData;

    logic              w_aluGrant;
    logic              w_memGrant;
    logic              w_contested;
    logic [ADDR_W-1:0] w_xferReg;
    logic [DATA_W-1:0] w_xferData;

    always_comb begin
        w_aluGrant  = 1'b0;
        w_memGrant  = 1'b0;
        w_contested = 1'b0;
        if (r_state == RUN) begin
            if (bus.AluValid && bus.MemValid) begin
                w_contested = 1'b1;
                w_aluGrant  = !r_prio;
                w_memGrant  = r_prio;
            end else begin
                w_aluGrant  = bus.AluValid;
                w_memGrant  = bus.MemValid;
            end
        end
        w_xferReg  = w_memGrant ? bus.MemReg  : bus.AluReg;
        w_xferData = w_memGrant ? bus.MemData : bus.AluData;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= CLEAR;
            r_clrIdx    <= '0;
            r_prio      <= 1'b0;
            r_regWrite  <= 1'b0;
            r_zeroDrop  <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_regWrite  <= 1'b1;
                    r_zeroDrop  <= 1'b0;
                    r_writeReg  <= r_clrIdx;
                    r_writeData <= '0;
                    if (r_clrIdx == c_LAST_IDX) begin
                        r_state  <= RUN;
                        r_clrIdx <= '0;
                    end else begin
                        r_clrIdx <= r_clrIdx + c_ONE;
                    end
                end
                RUN: begin
                    if (w_aluGrant || w_memGrant) begin
                        // Writes to register 0 are consumed but never reach the file.
                        r_writeReg  <= w_xferReg;
                        r_writeData <= w_xferData;
                        r_regWrite  <= (w_xferReg != '0);
                        r_zeroDrop  <= (w_xferReg == '0);
                    end else begin
                        r_regWrite  <= 1'b0;
                        r_zeroDrop  <= 1'b0;
                    end
                    if (w_contested) begin
                        r_prio <= !r_prio;
                    end
                    if (bus.ClearReq) begin
                        r_state  <= CLEAR;
                        r_clrIdx <= '0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign bus.AluReady      = w_aluGrant;
    assign bus.MemReady      = w_memGrant;
    assign bus.Busy          = (r_state == CLEAR);
    assign bus.ZeroDrop      = r_zeroDrop;
    assign bus.WriteRegister = r_writeReg;
    assign bus.WriteData     = r_writeData;
    assign bus.RegWrite      = r_regWrite;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench with a negedge-write register file.
// Revision    : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;
    logic Clk = 1'b0;
    logic Rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] r_mem [32];

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (bus.RegWrite) r_mem[bus.WriteRegister] <= bus.WriteData;
    end

    task automatic test_reset();
        bus.AluValid = 1'b0; bus.AluReg = '0; bus.AluData = '0;
        bus.MemValid = 1'b0; bus.MemReg = '0; bus.MemData = '0;
        bus.ClearReq = 1'b0;
        #1 Rst_n = 1'b0;
        bus.AluValid = 1'b1;
        #2;
        n_checks++; if (bus.RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %b want 0", bus.RegWrite); end
        n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", bus.Busy); end
        n_checks++; if (bus.WriteRegister !== 5'd0 || bus.WriteData !== 32'd0 || bus.ZeroDrop !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs got reg=%0d data=%h zd=%b want 0/0/0", bus.WriteRegister, bus.WriteData, bus.ZeroDrop); end
        n_checks++; if (bus.AluReady !== 1'b0) begin n_fail++; $display("FAIL reset_aluready got %b want 0", bus.AluReady); end
        bus.AluValid = 1'b0;
        @(negedge Clk) Rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge Clk); #1;
            n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(i) || bus.WriteData !== 32'd0) begin
                n_fail++; $display("FAIL clear_seq[%0d] got we=%b reg=%0d data=%h want 1/%0d/0", i, bus.RegWrite, bus.WriteRegister, bus.WriteData, i); end
            n_checks++; if (bus.Busy !== (i < 31)) begin n_fail++; $display("FAIL clear_busy[%0d] got %b want %b", i, bus.Busy, (i < 31)); end
        end
        @(negedge Clk); #1;
        for (int r = 0; r < 32; r++) begin
            n_checks++; if (r_mem[r] !== 32'd0) begin n_fail++; $display("FAIL clear_mem[%0d] got %h want 0", r, r_mem[r]); end
        end
    endtask

    task automatic test_alu_write();
        @(posedge Clk); #1;
        n_checks++; if (bus.RegWrite !== 1'b0) begin n_fail++; $display("FAIL idle_regwrite got %b want 0", bus.RegWrite); end
        bus.AluValid = 1'b1; bus.AluReg = 5'd5; bus.AluData = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.AluReady !== 1'b1 || bus.MemReady !== 1'b0) begin
            n_fail++; $display("FAIL alu_ready got alu=%b mem=%b want 1/0", bus.AluReady, bus.MemReady); end
        @(posedge Clk); #1;
        n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alu_write got we=%b reg=%0d data=%h want 1/5/deadbeef", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
        bus.AluValid = 1'b0;
        @(negedge Clk); #1;
        n_checks++; if (r_mem[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_mem5 got %h want deadbeef", r_mem[5]); end
    endtask

    task automatic test_back_to_back();
        logic expMem;
        @(posedge Clk); #1;
        bus.AluValid = 1'b1; bus.AluReg = 5'd3; bus.AluData = 32'h33;
        bus.MemValid = 1'b1; bus.MemReg = 5'd4; bus.MemData = 32'h44;
        for (int i = 0; i < 4; i++) begin
            expMem = (i % 2) == 1;
            #1;
            n_checks++; if (bus.AluReady !== !expMem || bus.MemReady !== expMem) begin
                n_fail++; $display("FAIL rr_grant[%0d] got alu=%b mem=%b want %b/%b", i, bus.AluReady, bus.MemReady, !expMem, expMem); end
            @(posedge Clk); #1;
            n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== (expMem ? 5'd4 : 5'd3)) begin
                n_fail++; $display("FAIL rr_write[%0d] got we=%b reg=%0d want 1/%0d", i, bus.RegWrite, bus.WriteRegister, expMem ? 4 : 3); end
        end
        bus.AluValid = 1'b0; bus.MemValid = 1'b0;
        @(negedge Clk); #1;
        n_checks++; if (r_mem[3] !== 32'h33 || r_mem[4] !== 32'h44) begin
            n_fail++; $display("FAIL rr_mem got r3=%h r4=%h want 33/44", r_mem[3], r_mem[4]); end
    endtask

    task automatic test_zero_drop();
        @(posedge Clk); #1;
        bus.MemValid = 1'b1; bus.MemReg = 5'd0; bus.MemData = 32'h1234;
        #1;
        n_checks++; if (bus.MemReady !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b want 1", bus.MemReady); end
        @(posedge Clk); #1;
        n_checks++; if (bus.ZeroDrop !== 1'b1 || bus.RegWrite !== 1'b0) begin
            n_fail++; $display("FAIL zero_drop got zd=%b we=%b want 1/0", bus.ZeroDrop, bus.RegWrite); end
        bus.MemValid = 1'b0;
        @(posedge Clk); #1;
        n_checks++; if (bus.ZeroDrop !== 1'b0) begin n_fail++; $display("FAIL zero_pulse got %b want 0", bus.ZeroDrop); end
        n_checks++; if (r_mem[0] !== 32'd0) begin n_fail++; $display("FAIL zero_mem0 got %h want 0", r_mem[0]); end
    endtask

    task automatic test_clear_req();
        @(posedge Clk); #1;
        bus.AluValid = 1'b1; bus.AluReg = 5'd7; bus.AluData = 32'h55;
        bus.ClearReq = 1'b1;
        #1;
        n_checks++; if (bus.AluReady !== 1'b1) begin n_fail++; $display("FAIL clrreq_ready got %b want 1", bus.AluReady); end
        @(posedge Clk); #1;
        n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd7 || bus.WriteData !== 32'h55 || bus.Busy !== 1'b1) begin
            n_fail++; $display("FAIL clrreq_write got we=%b reg=%0d data=%h busy=%b want 1/7/55/1", bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Busy); end
        bus.AluValid = 1'b0; bus.ClearReq = 1'b0;
        bus.MemValid = 1'b1; bus.MemReg = 5'd9; bus.MemData = 32'h99;
        #1;
        n_checks++; if (bus.MemReady !== 1'b0) begin n_fail++; $display("FAIL clrreq_ready0 got %b want 0", bus.MemReady); end
        @(negedge Clk); #1;
        n_checks++; if (r_mem[7] !== 32'h55) begin n_fail++; $display("FAIL clrreq_mem7 got %h want 55", r_mem[7]); end
        for (int i = 0; i < 32; i++) begin
            @(posedge Clk); #1;
            n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(i) || bus.WriteData !== 32'd0) begin
                n_fail++; $display("FAIL clrreq_seq[%0d] got we=%b reg=%0d data=%h want 1/%0d/0", i, bus.RegWrite, bus.WriteRegister, bus.WriteData, i); end
            if (i < 31) begin
                n_checks++; if (bus.MemReady !== 1'b0 || bus.Busy !== 1'b1) begin
                    n_fail++; $display("FAIL clrreq_hold[%0d] got ready=%b busy=%b want 0/1", i, bus.MemReady, bus.Busy); end
            end else begin
                bus.MemValid = 1'b0;
            end
        end
        @(negedge Clk); #1;
        n_checks++; if (r_mem[7] !== 32'd0) begin n_fail++; $display("FAIL clrreq_mem7_final got %h want 0", r_mem[7]); end
    endtask

    task automatic test_reset_mid_clear();
        @(posedge Clk); #1;
        bus.ClearReq = 1'b1;
        @(posedge Clk); #1;
        bus.ClearReq = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge Clk); #1;
        end
        n_checks++; if (bus.WriteRegister !== 5'd9) begin n_fail++; $display("FAIL midclr_pos got %0d want 9", bus.WriteRegister); end
        Rst_n = 1'b0;
        #1;
        n_checks++; if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0 || bus.Busy !== 1'b1) begin
            n_fail++; $display("FAIL midclr_reset got we=%b reg=%0d busy=%b want 0/0/1", bus.RegWrite, bus.WriteRegister, bus.Busy); end
        @(negedge Clk) Rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(posedge Clk); #1;
            n_checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(i) || bus.Busy !== (i < 31)) begin
                n_fail++; $display("FAIL midclr_seq[%0d] got we=%b reg=%0d busy=%b want 1/%0d/%b", i, bus.RegWrite, bus.WriteRegister, bus.Busy, i, (i < 31)); end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) r_mem[r] = 32'hA5A50000 | r;
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_zero_drop();
        test_clear_req();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 register file's single write port. It clears all registers after reset or on request. It then arbitrates between two write-back requesters, the ALU path and the memory-load path, with a round-robin valid/ready handshake. It drives WriteRegister/WriteData/RegWrite from posedge flops, so the register file's negedge write sees stable values half a cycle later.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
NUM_REGS, 32, registers cleared by the CLEAR sequence; must equal 2**ADDR_W

Ports:
Clk  in  1  system clock; all flops on posedge
Rst_n  in  1  asynchronous active-low reset
AluValid  in  1  ALU write-back request
AluReg  in  ADDR_W  ALU destination register
AluData  in  DATA_W  ALU result
AluReady  out  1  ALU request accepted this cycle
MemValid  in  1  load write-back request
MemReg  in  ADDR_W  load destination register
MemData  in  DATA_W  load data
MemReady  out  1  load request accepted this cycle
ClearReq  in  1  single-cycle pulse: re-zero all registers
Busy  out  1  high while in CLEAR
ZeroDrop  out  1  one-cycle pulse: an accepted write targeted register 0 and was discarded
WriteRegister  out  ADDR_W  to register file
WriteData  out  DATA_W  to register file
RegWrite  out  1  to register file

Behaviour:
- Reset (async, Rst_n=0):
  - State enters CLEAR; ClrIdx=0; round-robin pointer Prio=ALU.
  - RegWrite=0, WriteRegister=0, WriteData=0, ZeroDrop=0, Busy=1.
  - AluReady=MemReady=0.
- States: CLEAR, RUN.
- CLEAR:
  - Each cycle registers RegWrite=1, WriteRegister=ClrIdx, WriteData=0.
  - ClrIdx increments each cycle.
  - After the cycle that issues ClrIdx=NUM_REGS-1, go to RUN and reset ClrIdx to 0.
  - Lasts exactly NUM_REGS cycles: writes 0..31, including register 0.
  - Both Ready outputs held 0; ClearReq ignored; Busy=1.
- RUN:
  - Busy=0.
  - Ready outputs are combinational from Valid inputs and Prio:
    - only one Valid high: that requester's Ready=1.
    - both Valid high: the requester named by Prio gets Ready=1, the other Ready=0.
    - neither Valid high: both Ready=0.
  - Transfer occurs when Valid&Ready. At most one transfer per cycle.
  - Prio flips to the loser only after a contested cycle (both Valid); it is unchanged after an uncontested grant.
- Output timing:
  - A transfer at posedge N registers WriteRegister/WriteData at N.
  - RegWrite=1 for cycle N..N+1; the register file commits at the intervening negedge.
  - The data is readable from the register file after that negedge.
- Register 0:
  - A transfer with Reg=0 is accepted (Ready=1, consumed).
  - RegWrite=0 for that cycle and ZeroDrop=1 for one cycle.
  - WriteRegister/WriteData still update and are don't-care.
- No transfer in a cycle: RegWrite=0; WriteRegister/WriteData hold their last values.
- ClearReq in RUN:
  - Same-edge arbitration still completes; that cycle's transfer is written.
  - The next cycle enters CLEAR from ClrIdx=0.
  - Ready outputs drop in that next cycle.
- Same destination from both requesters in a contested cycle:
  - Written serially: the winner this cycle, the loser in a later cycle.
  - The last write wins. Ordering hazards are the requesters' responsibility.
- Reset mid-CLEAR or mid-RUN: immediate return to reset values; the sequence restarts from ClrIdx=0 when Rst_n rises.
- Requesters must hold Valid/Reg/Data stable until Ready. The block does not check this.

Test Plan:
- Reset release -> Busy=1 and RegWrite=1 for exactly 32 cycles with WriteRegister 0,1,...,31 and WriteData=0; then Busy=0; every register reads 0.
- RUN, AluValid=1 AluReg=5 AluData=0xDEADBEEF, MemValid=0 -> AluReady=1 same cycle; next cycle RegWrite=1 WriteRegister=5; ReadData of reg 5 = 0xDEADBEEF after the negedge.
- Both Valid held 4 cycles with distinct regs 3/4 and Prio=ALU at start -> grants ALU,MEM,ALU,MEM; RegWrite high all 4 cycles; no grant lost.
- MemValid=1 MemReg=0 MemData=0x1234 -> MemReady=1, ZeroDrop=1 for 1 cycle, RegWrite=0; reg 0 still reads 0.
- ClearReq pulsed in the same cycle as an ALU write to reg 7=0x55 -> reg 7 written 0x55, then 32-cycle CLEAR; Ready=0 throughout; reg 7 finally reads 0.
- Rst_n asserted at ClrIdx=10 of CLEAR -> outputs zero immediately; after release CLEAR restarts at WriteRegister=0 and runs the full 32 cycles.
